// File: rtl/alu_sequencer.sv
// Issue/collect front end for the 8-bit accumulator ALU: queues instruction words,
// issues each one for exactly one cycle, waits out the ALU latency and returns the result.
module alu_sequencer #(
  parameter int         DEPTH   = 4,
  parameter int         ALU_LAT = 1,
  parameter logic [3:0] NOP_OP  = 4'b1111
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic [3:0]               alu_opcode,
  output logic [7:0]               alu_a,
  output logic [7:0]               alu_b,
  input  logic [7:0]               alu_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_result,
  output logic [3:0]               out_opcode,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_INIT = LW'(ALU_LAT - 1);

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  instr_t            mem [DEPTH];
  instr_t            head;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;
  logic              capture;
  state_t            state;
  state_t            next_state;
  logic [3:0]        tag;
  logic [LW-1:0]     cnt;

  // in_ready looks only at the registered count, never at a same-cycle pop.
  assign in_ready = (count < FULL);
  assign push     = in_valid && in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE);

  // NOTE: storage has no reset; validity is tracked by count and the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: in_opcode, a: in_a, b: in_b};
    end
  end

  // NOTE: every clocked register uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (count != '0) begin
            pop        = 1'b1;
            next_state = ISSUE;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The free-running ALU sees a real opcode only during ISSUE, so it executes each word once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= NOP_OP;
      alu_a      <= '0;
      alu_b      <= '0;
      tag        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_opcode <= '0;
    end else begin
      if (pop) begin
        alu_opcode <= head.opcode;
        alu_a      <= head.a;
        alu_b      <= head.b;
        tag        <= head.opcode;
      end else if (state == ISSUE) begin
        alu_opcode <= NOP_OP;
        cnt        <= LAT_INIT;
      end

      if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end

      if (capture) begin
        out_result <= alu_out;
        out_opcode <= tag;
        out_valid  <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small accumulator-ALU model:
// ADD acc=A+B, SUB acc=A-B, ADDA acc=acc+A, any other opcode leaves acc unchanged.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic [3:0] out_opcode;
  logic       busy;
  logic [2:0] count;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDA = 4'b0010;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_opcode (out_opcode),
    .busy       (busy),
    .count      (count)
  );

  // ALU model: registered, no reset, one edge of latency.
  logic [7:0] acc;
  always @(posedge clk) begin
    case (alu_opcode)
      OP_ADD:  acc <= alu_a + alu_b;
      OP_SUB:  acc <= alu_a - alu_b;
      OP_ADDA: acc <= acc + alu_a;
      default: acc <= acc;
    endcase
  end
  assign alu_out = acc;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_res;
    int         hold;
  } vec_t;

  vec_t tbl [9];
  vec_t bp  [6];
  vec_t sim [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok = 1'b0;
    in_opcode = op;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    check({name, "_valid"}, out_valid, 1);
  endtask

  task automatic collect(input string name, input logic [3:0] op, input logic [7:0] res, input int hold);
    wait_valid(name);
    check({name, "_result"}, out_result, res);
    check({name, "_opcode"}, out_opcode, op);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check({name, "_held_result"}, out_result, res);
      check({name, "_held_valid"}, out_valid, 1);
      check({name, "_held_nop"}, alu_opcode, OP_NOP);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_accepted"}, out_valid, 0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_count"},      count, 0);
    check({name, "_in_ready"},   in_ready, 1);
    check({name, "_busy"},       busy, 0);
    check({name, "_alu_opcode"}, alu_opcode, OP_NOP);
    check({name, "_alu_a"},      alu_a, 0);
    check({name, "_alu_b"},      alu_b, 0);
    check({name, "_out_valid"},  out_valid, 0);
    check({name, "_out_result"}, out_result, 0);
    check({name, "_out_opcode"}, out_opcode, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Accumulator chain 7 -> 17 -> 11 with 10-cycle holds, then wrap cases.
    tbl[0] = '{OP_ADD,  8'd3,   8'd4,   8'd7,    10};
    tbl[1] = '{OP_ADDA, 8'd10,  8'd0,   8'd17,   10};
    tbl[2] = '{OP_ADDA, 8'd250, 8'd0,   8'd11,   10};
    tbl[3] = '{OP_SUB,  8'd5,   8'd7,   8'hFE,   0};
    tbl[4] = '{OP_ADD,  8'd200, 8'd100, 8'h2C,   2};
    tbl[5] = '{OP_SUB,  8'd0,   8'd1,   8'hFF,   0};
    tbl[6] = '{OP_ADDA, 8'd1,   8'd0,   8'h00,   0};
    tbl[7] = '{4'b0011, 8'd9,   8'd9,   8'h00,   3};
    tbl[8] = '{OP_ADD,  8'd255, 8'd1,   8'h00,   0};

    bp[0] = '{OP_ADD, 8'd1,   8'd2,  8'h03, 0};
    bp[1] = '{OP_SUB, 8'd11,  8'd3,  8'h08, 0};
    bp[2] = '{OP_ADD, 8'd21,  8'd4,  8'h19, 0};
    bp[3] = '{OP_SUB, 8'd31,  8'd5,  8'h1A, 0};
    bp[4] = '{OP_ADD, 8'd250, 8'd10, 8'h04, 0};
    bp[5] = '{OP_SUB, 8'd3,   8'd9,  8'hFA, 0};

    sim[0] = '{OP_ADD, 8'd5,   8'd5,  8'd10,  0};
    sim[1] = '{OP_ADD, 8'd6,   8'd6,  8'd12,  0};
    sim[2] = '{OP_SUB, 8'd7,   8'd1,  8'd6,   0};
    sim[3] = '{OP_ADD, 8'd100, 8'd28, 8'h80,  0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    // Single ADD timing: push accepted at P, pop at P+1, issue cycle, result after P+3.
    push(OP_ADD, 8'd3, 8'd4);
    check("t_p0_count", count, 1);
    check("t_p0_nop", alu_opcode, OP_NOP);
    @(negedge clk);
    check("t_p1_issue_op", alu_opcode, OP_ADD);
    check("t_p1_alu_a", alu_a, 8'd3);
    check("t_p1_busy", busy, 1);
    check("t_p1_count", count, 0);
    @(negedge clk);
    check("t_p2_nop", alu_opcode, OP_NOP);
    check("t_p2_alu_a_kept", alu_a, 8'd3);
    check("t_p2_no_valid", out_valid, 0);
    @(negedge clk);
    check("t_p3_valid", out_valid, 1);
    check("t_p3_result", out_result, 8'd7);
    check("t_p3_opcode", out_opcode, OP_ADD);
    collect("t_single", OP_ADD, 8'd7, 0);
    check("t_idle_busy", busy, 0);

    foreach (tbl[i]) begin
      push(tbl[i].op, tbl[i].a, tbl[i].b);
      collect($sformatf("tbl%0d", i), tbl[i].op, tbl[i].exp_res, tbl[i].hold);
    end

    // Backpressure: first word popped and held, four queued, sixth stalls.
    for (int k = 0; k < 5; k++) push(bp[k].op, bp[k].a, bp[k].b);
    check("bp_full_count", count, 4);
    check("bp_full_ready", in_ready, 0);
    in_opcode = bp[5].op;
    in_a      = bp[5].a;
    in_b      = bp[5].b;
    in_valid  = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_stall_count", count, 4);
    check("bp_stall_ready", in_ready, 0);
    check("bp_stall_first", out_result, bp[0].exp_res);
    begin
      int got = 0;
      fork
        push(bp[5].op, bp[5].a, bp[5].b);
        begin
          out_ready = 1'b1;
          for (int c = 0; c < 200 && got < 6; c++) begin
            if (out_valid) begin
              check($sformatf("bp%0d_result", got), out_result, bp[got].exp_res);
              check($sformatf("bp%0d_opcode", got), out_opcode, bp[got].op);
              got++;
            end
            @(negedge clk);
          end
          out_ready = 1'b0;
        end
      join
      check("bp_result_count", got, 6);
    end
    repeat (2) @(negedge clk);
    check("bp_drained_count", count, 0);
    check("bp_drained_busy", busy, 0);

    // Push on the same edge as a HOLD-accept pop: count stays at 2.
    for (int k = 0; k < 3; k++) push(sim[k].op, sim[k].a, sim[k].b);
    wait_valid("sim_first");
    check("sim_pre_count", count, 2);
    check("sim0_result", out_result, sim[0].exp_res);
    in_opcode = sim[3].op;
    in_a      = sim[3].a;
    in_b      = sim[3].b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("sim_post_count", count, 2);
    check("sim_post_alu_a", alu_a, sim[1].a);
    for (int k = 1; k < 4; k++) collect($sformatf("sim%0d", k), sim[k].op, sim[k].exp_res, 0);
    repeat (2) @(negedge clk);
    check("sim_drained_count", count, 0);

    // Reset in WAIT with three words queued.
    push(OP_SUB, 8'd9, 8'd2);
    push(OP_ADD, 8'd20, 8'd30);
    push(OP_ADD, 8'd1, 8'd2);
    push(OP_SUB, 8'd3, 8'd4);
    push(OP_ADD, 8'd5, 8'd6);
    wait_valid("rst_first");
    check("rst_first_result", out_result, 8'd7);
    check("rst_first_opcode", out_opcode, OP_SUB);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("rst_issue_count", count, 3);
    check("rst_issue_op", alu_opcode, OP_ADD);
    check("rst_issue_a", alu_a, 8'd20);
    @(negedge clk);
    check("rst_wait_count", count, 3);
    check("rst_wait_nop", alu_opcode, OP_NOP);
    check("rst_wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_after_count", count, 0);
    check("rst_after_busy", busy, 0);
    check("rst_after_valid", out_valid, 0);
    push(OP_ADD, 8'd1, 8'd1);
    collect("rst_readd", OP_ADD, 8'd2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
